// File: rtl/text_pixel_render_if.sv
// Pixel-stream bundle between the text overlay front end, the font ROM and the renderer.
interface text_pixel_render_if #(
  parameter int unsigned RGB_W = 12
);
  logic             pix_tick;
  logic             frame_tick;
  logic             video_on;
  logic             hsync;
  logic             vsync;
  logic [RGB_W-1:0] bg_rgb;
  logic             text_on;
  logic [2:0]       bit_addr;
  logic [10:0]      rom_addr;
  logic             blink_en;
  logic [10:0]      font_addr;
  logic [7:0]       font_data;
  logic [RGB_W-1:0] rgb_o;
  logic             hsync_o;
  logic             vsync_o;

  // Pixel source / ROM side
  modport master (
    output pix_tick, frame_tick, video_on, hsync, vsync, bg_rgb,
           text_on, bit_addr, rom_addr, blink_en, font_data,
    input  font_addr, rgb_o, hsync_o, vsync_o
  );

  // Renderer side
  modport slave (
    input  pix_tick, frame_tick, video_on, hsync, vsync, bg_rgb,
           text_on, bit_addr, rom_addr, blink_en, font_data,
    output font_addr, rgb_o, hsync_o, vsync_o
  );
endinterface

// File: rtl/text_pixel_render.sv
// Text overlay pixel renderer: font ROM lookup, glyph/background mix, sync
// alignment and a frame-synchronous blink gate.
module text_pixel_render #(
  parameter int unsigned     RGB_W        = 12,
  parameter logic [RGB_W-1:0] FG_RGB      = 12'hFFF,
  parameter int unsigned     BLINK_FRAMES = 30,
  parameter int unsigned     CNT_W        = 6,
  parameter logic            SYNC_IDLE    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  text_pixel_render_if.slave   bus
);

  localparam int unsigned BIT_W = 3;

  typedef enum logic [1:0] {
    ST_SOLID = 2'd0,
    ST_SHOW  = 2'd1,
    ST_HIDE  = 2'd2
  } blink_state_e;

  blink_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             tick_d1_q;
  logic             text_on_a_q;
  logic [BIT_W-1:0] bit_addr_a_q;
  logic             video_on_a_q;
  logic             hsync_a_q;
  logic             vsync_a_q;
  logic [RGB_W-1:0] bg_rgb_a_q;

  logic [RGB_W-1:0] rgb_q;
  logic             hsync_q;
  logic             vsync_q;

  logic             glyph_bit_c;
  logic             visible_c;

  // ROM address goes straight out so the ROM samples it on the pix_tick edge
  assign bus.font_addr = bus.rom_addr;

  // Blink state and frame counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SOLID;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Blink next-state: only frame_tick edges move the FSM, so visibility is stable within a frame
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.frame_tick) begin
      case (state_q)
        ST_SOLID: begin
          if (bus.blink_en) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end
        end
        ST_SHOW, ST_HIDE: begin
          if (!bus.blink_en) begin
            state_d = ST_SOLID;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
            state_d = (state_q == ST_SHOW) ? ST_HIDE : ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_SOLID;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Stage A: capture pixel sidebands while the ROM fetches the glyph row
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_d1_q    <= 1'b0;
      text_on_a_q  <= 1'b0;
      bit_addr_a_q <= '0;
      video_on_a_q <= 1'b0;
      hsync_a_q    <= SYNC_IDLE;
      vsync_a_q    <= SYNC_IDLE;
      bg_rgb_a_q   <= '0;
    end else begin
      tick_d1_q <= bus.pix_tick;
      if (bus.pix_tick) begin
        text_on_a_q  <= bus.text_on;
        bit_addr_a_q <= bus.bit_addr;
        video_on_a_q <= bus.video_on;
        hsync_a_q    <= bus.hsync;
        vsync_a_q    <= bus.vsync;
        bg_rgb_a_q   <= bus.bg_rgb;
      end
    end
  end

  // MSB of the font row is the leftmost pixel
  assign glyph_bit_c = bus.font_data[BIT_W'(3'd7 - bit_addr_a_q)];
  assign visible_c   = (state_q != ST_HIDE);

  // Stage B: colour mix and sync alignment, one edge after stage A
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q   <= '0;
      hsync_q <= SYNC_IDLE;
      vsync_q <= SYNC_IDLE;
    end else if (tick_d1_q) begin
      if (!video_on_a_q) begin
        rgb_q <= '0;
      end else if (text_on_a_q && glyph_bit_c && visible_c) begin
        rgb_q <= FG_RGB;
      end else begin
        rgb_q <= bg_rgb_a_q;
      end
      hsync_q <= hsync_a_q;
      vsync_q <= vsync_a_q;
    end
  end

  assign bus.rgb_o   = rgb_q;
  assign bus.hsync_o = hsync_q;
  assign bus.vsync_o = vsync_q;

endmodule

// File: tb/tb_text_pixel_render.sv
// Testbench for text_pixel_render: fixed vectors, blink/reset sequences and a
// randomized run scored against a frame-level reference model.
module tb_text_pixel_render;

  localparam int unsigned RGB_W = 12;
  localparam int unsigned BF    = 2;
  localparam logic [11:0] FG    = 12'hFFF;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  text_pixel_render_if #(.RGB_W(RGB_W)) bus ();

  text_pixel_render #(.RGB_W(RGB_W), .BLINK_FRAMES(BF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External font ROM, one-clock read latency
  logic [7:0] font_rom [2048];
  always @(posedge clk) bus.font_data <= font_rom[bus.font_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: blink phase derived from the number of frames since blinking started
  logic        m_blinking;
  int          m_frames;
  logic        pend;
  logic [11:0] exp_rgb, last_rgb, rgb_now;
  logic        exp_hs, exp_vs, last_hs, last_vs, hs_now, vs_now;
  logic        tick_now, rst_now;

  function automatic logic [11:0] ref_rgb(input logic t, input logic v, input logic [2:0] b,
                                          input logic [10:0] a, input logic [11:0] bg,
                                          input logic vis);
    logic [7:0] row;
    row = font_rom[a];
    if (!v) return 12'h000;
    if (t && row[7 - int'(b)] && vis) return FG;
    return bg;
  endfunction

  // Scoreboard: every edge either delivers the pixel ticked one edge earlier or holds
  always @(posedge clk) begin
    rst_now  = rst;
    tick_now = 1'b0;
    if (rst) begin
      m_blinking = 1'b0;
      m_frames   = 0;
    end else begin
      if (bus.frame_tick) begin
        if (!m_blinking) begin
          if (bus.blink_en) begin
            m_blinking = 1'b1;
            m_frames   = 0;
          end
        end else if (!bus.blink_en) begin
          m_blinking = 1'b0;
        end else begin
          m_frames++;
        end
      end
      tick_now = bus.pix_tick;
      rgb_now  = ref_rgb(bus.text_on, bus.video_on, bus.bit_addr, bus.rom_addr, bus.bg_rgb,
                         !m_blinking || ((m_frames / BF) % 2 == 0));
      hs_now   = bus.hsync;
      vs_now   = bus.vsync;
    end
    #1;
    if (rst_now) begin
      check("reset rgb_o", 32'(bus.rgb_o), 32'h0);
      check("reset hsync_o", 32'(bus.hsync_o), 32'h1);
      check("reset vsync_o", 32'(bus.vsync_o), 32'h1);
      last_rgb = 12'h000;
      last_hs  = 1'b1;
      last_vs  = 1'b1;
    end else begin
      if (pend) begin
        last_rgb = exp_rgb;
        last_hs  = exp_hs;
        last_vs  = exp_vs;
      end
      check("model rgb_o", 32'(bus.rgb_o), 32'(last_rgb));
      check("model hsync_o", 32'(bus.hsync_o), 32'(last_hs));
      check("model vsync_o", 32'(bus.vsync_o), 32'(last_vs));
    end
    pend    = tick_now;
    exp_rgb = rgb_now;
    exp_hs  = hs_now;
    exp_vs  = vs_now;
  end

  typedef struct {
    logic        text_on;
    logic        video_on;
    logic [2:0]  bit_addr;
    logic [10:0] rom_addr;
    logic [11:0] bg;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic tick_pixel(input logic t, input logic v, input logic [2:0] b,
                            input logic [10:0] a, input logic [11:0] bg,
                            input logic hs, input logic vs, input logic ft);
    @(negedge clk);
    bus.pix_tick   = 1'b1;
    bus.frame_tick = ft;
    bus.text_on    = t;
    bus.video_on   = v;
    bus.bit_addr   = b;
    bus.rom_addr   = a;
    bus.bg_rgb     = bg;
    bus.hsync      = hs;
    bus.vsync      = vs;
    @(negedge clk);
    bus.pix_tick   = 1'b0;
    bus.frame_tick = 1'b0;
  endtask

  task automatic frame_start();
    tick_pixel(1'b0, 1'b0, 3'd0, 11'h000, 12'h000, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  // Lit glyph pixel (row 8'hC3, column 0) with a known background
  task automatic lit_pixel(input string name, input logic [11:0] exp);
    tick_pixel(1'b1, 1'b1, 3'd0, 11'h530, 12'h246, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check(name, 32'(bus.rgb_o), 32'(exp));
    @(negedge clk);
  endtask

  logic hs_hist [24];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    pend    = 1'b0;
    for (int i = 0; i < 2048; i++) font_rom[i] = 8'($urandom);
    font_rom[11'h530] = 8'hC3;
    font_rom[11'h7F5] = 8'h18;

    vecs[0]  = '{1'b1, 1'b1, 3'd0, 11'h530, 12'h123, 12'hFFF};
    vecs[1]  = '{1'b1, 1'b1, 3'd1, 11'h530, 12'h123, 12'hFFF};
    vecs[2]  = '{1'b1, 1'b1, 3'd2, 11'h530, 12'h123, 12'h123};
    vecs[3]  = '{1'b1, 1'b1, 3'd3, 11'h530, 12'h123, 12'h123};
    vecs[4]  = '{1'b1, 1'b1, 3'd4, 11'h530, 12'h123, 12'h123};
    vecs[5]  = '{1'b1, 1'b1, 3'd5, 11'h530, 12'h123, 12'h123};
    vecs[6]  = '{1'b1, 1'b1, 3'd6, 11'h530, 12'h123, 12'hFFF};
    vecs[7]  = '{1'b1, 1'b1, 3'd7, 11'h530, 12'h123, 12'hFFF};
    vecs[8]  = '{1'b0, 1'b1, 3'd0, 11'h530, 12'h0A5, 12'h0A5};
    vecs[9]  = '{1'b1, 1'b0, 3'd1, 11'h530, 12'h0A5, 12'h000};
    vecs[10] = '{1'b1, 1'b1, 3'd3, 11'h7F5, 12'h321, 12'hFFF};
    vecs[11] = '{1'b1, 1'b1, 3'd2, 11'h7F5, 12'h321, 12'h321};

    rst            = 1'b1;
    bus.pix_tick   = 1'b0;
    bus.frame_tick = 1'b0;
    bus.video_on   = 1'b0;
    bus.hsync      = 1'b1;
    bus.vsync      = 1'b1;
    bus.bg_rgb     = '0;
    bus.text_on    = 1'b0;
    bus.bit_addr   = '0;
    bus.rom_addr   = '0;
    bus.blink_en   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Fixed vectors, one pix_tick every 4th clock
    for (int i = 0; i < 12; i++) begin
      tick_pixel(vecs[i].text_on, vecs[i].video_on, vecs[i].bit_addr, vecs[i].rom_addr,
                 vecs[i].bg, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check($sformatf("vec%0d rgb_o", i), 32'(bus.rgb_o), 32'(vecs[i].exp));
      check($sformatf("vec%0d hsync_o", i), 32'(bus.hsync_o), 32'h0);
      @(negedge clk);
    end

    // Full-rate pipeline with hsync toggling every clock
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i >= 2) check($sformatf("fullrate hsync_o %0d", i), 32'(bus.hsync_o), 32'(hs_hist[i-2]));
      if (i == 8) check("fullrate video_off rgb_o", 32'(bus.rgb_o), 32'h000);
      if (i == 9) check("fullrate lit rgb_o", 32'(bus.rgb_o), 32'hFFF);
      hs_hist[i]   = i[0];
      bus.pix_tick = 1'b1;
      bus.hsync    = i[0];
      bus.vsync    = ~i[0];
      bus.text_on  = 1'b1;
      bus.video_on = (i != 6);
      bus.rom_addr = 11'h530;
      bus.bit_addr = (i == 6 || i == 7) ? 3'd0 : 3'(i);
      bus.bg_rgb   = 12'h5A5;
    end
    @(negedge clk);
    bus.pix_tick = 1'b0;
    repeat (3) @(negedge clk);

    // Blink: two frames shown, two hidden; drop blink_en mid frame 4
    bus.blink_en = 1'b1;
    for (int f = 1; f <= 6; f++) begin
      frame_start();
      lit_pixel($sformatf("blink frame%0d", f), (f == 3 || f == 4) ? 12'h246 : 12'hFFF);
      if (f == 4) begin
        bus.blink_en = 1'b0;
        lit_pixel("blink drop mid frame", 12'h246);
      end
    end

    // Reset while hidden, then restart blinking
    bus.blink_en = 1'b1;
    frame_start();
    lit_pixel("rb show1", 12'hFFF);
    frame_start();
    lit_pixel("rb show2", 12'hFFF);
    frame_start();
    lit_pixel("rb hide", 12'h246);
    @(negedge clk);
    rst = 1'b1;
    bus.pix_tick = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.pix_tick = 1'b0;
    check("midreset rgb_o", 32'(bus.rgb_o), 32'h0);
    @(negedge clk);
    lit_pixel("post reset solid", 12'hFFF);
    frame_start();
    lit_pixel("post reset show", 12'hFFF);
    frame_start();
    frame_start();
    lit_pixel("post reset hide", 12'h246);

    // Randomized traffic with bursts of held pix_tick, frames and occasional resets
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst            = ($urandom_range(0, 199) == 0);
      bus.pix_tick   = ((i / 64) % 3 == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.frame_tick = bus.pix_tick && ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) bus.blink_en = ~bus.blink_en;
      bus.video_on   = ($urandom_range(0, 7) != 0);
      bus.text_on    = ($urandom_range(0, 5) != 0);
      bus.bit_addr   = 3'($urandom);
      bus.rom_addr   = 11'($urandom);
      bus.bg_rgb     = 12'($urandom);
      bus.hsync      = 1'($urandom);
      bus.vsync      = 1'($urandom);
    end
    @(negedge clk);
    rst            = 1'b0;
    bus.pix_tick   = 1'b0;
    bus.frame_tick = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
